sprite_cmd_encoder: RTL and testbench
=====================================

# sprite_cmd_encoder

Command-word transmitter for the sprite display peripherals. It sits between the frame-update controller and the display block's 32-bit `writedata` bus. It accepts one sprite descriptor per handshake and serialises it into the four command words the display decodes: pattern/flags, X, Y and attribute. On request it also emits the buffer-swap word that flips the display's front/back sprite buffers. It tracks the front buffer internally, so every update is always written to the back buffer.

## Interface
Parameters:
- `WORD_CYCLES`, 1 — cycles each non-idle word is held on `writedata`; legal range 1..15.
- `GAP_CYCLES`, 1 — cycles of idle word (32'h0) after each non-idle word; legal range 1..15.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  sprite descriptor valid.
- `req_ready`  out  1  encoder can accept a descriptor.
- `req_component`  in  6  target component ID; goes to word bits [31:26].
- `req_subcomponent`  in  5  subcomponent index; goes to word bits [25:21].
- `req_pattern`  in  5  pattern index; passed unchecked.
- `req_visible`  in  1  visibility flag.
- `req_flip`  in  1  horizontal flip flag.
- `req_x`  in  10  X position.
- `req_y`  in  10  Y position.
- `req_attr`  in  10  additional attribute.
- `commit_valid`  in  1  request a buffer swap.
- `commit_ready`  out  1  encoder can accept a swap.
- `writedata`  out  32  command word to the display blocks; registered.
- `front_buf`  out  1  buffer currently displayed; the back buffer is `~front_buf`.
- `busy`  out  1  a sequence is in progress (state ≠ IDLE).

## Operation
Word format:
- [31:26] component
- [25:21] subcomponent
- [20:17] command
- [16:14] type
- [13] buffer
- [12:0] data

Sprite update (command 4'b0001, buffer = `~front_buf` sampled at accept), emitted in this order:
- w0: type 3'b001, data = {visible, flip, 6'b0, pattern}.
- w1: type 3'b010, data = {3'b0, x}.
- w2: type 3'b011, data = {3'b0, y}.
- w3: type 3'b100, data = {3'b0, attr}.

Swap word: fields [31:26], [25:21], [16:14] and [12:0] are 0; command = 4'b1111; buffer = `~front_buf` (the new front). When the swap word is first driven, `front_buf` toggles.

Idle word: 32'h0. Command 0 is ignored by every display block.

State machine:
- States: IDLE, WORD, GAP. Registers: 2-bit word index, 4-bit hold counter, a "swap" flag, and the latched descriptor.
- IDLE: `req_ready` = 1. `commit_ready` = !`req_valid`, so a sprite request beats a simultaneous commit.
  - On req accept: latch the descriptor and back-buffer bit, drive w0, index = 0, go to WORD.
  - On commit accept: drive the swap word, set the swap flag, go to WORD.
- WORD: hold the word for `WORD_CYCLES` cycles, then drive 32'h0 and go to GAP.
- GAP: hold 32'h0 for `GAP_CYCLES` cycles.
  - If more sprite words remain: index++, drive the next word, go to WORD.
  - Else (after w3 or after the swap): go to IDLE.
- Descriptor inputs are ignored outside the accept cycle. Changing them mid-sequence has no effect.
- The back-buffer bit is latched at accept. All four words of one sprite carry the same buffer bit.

Reset (asynchronous) sets the following, and any in-flight descriptor is discarded:
- state = IDLE
- `writedata` = 0
- `front_buf` = 0
- `busy` = 0
- counters = 0

`req_ready` and `commit_ready` are 0 while `reset` is high.

## Timing
- Accept occurs on the rising edge where valid && ready. The first word appears on `writedata` from that same edge.
- Sprite sequence length = 4·(`WORD_CYCLES`+`GAP_CYCLES`) cycles from accept to the first cycle with `req_ready` = 1. With defaults this is 8, so back-to-back sprites can be accepted every 8 cycles.
- Swap sequence length = `WORD_CYCLES`+`GAP_CYCLES` cycles.
- `front_buf` changes on the accept edge of the commit.
- `busy` = 1 from the accept edge until the edge that returns the FSM to IDLE.
- Every non-idle word is followed by at least one idle cycle.
- After reset is released, the first accept is possible on the first rising edge.

## Test plan
- Reset, then idle: `writedata` = 32'h0, `front_buf` = 0, `req_ready` = 1, `commit_ready` = 1.
- Sprite {comp 1, sub 0, pattern 7, visible 1, flip 0, x 100, y 200, attr 5} with defaults:
  - `writedata` sequence 0x04027007, 0, 0x0402A064, 0, 0x0402E0C8, 0, 0x04032005, 0.
  - `req_ready` is high again 8 cycles after accept.
- Commit from reset: `writedata` = 0x001E2000 for one cycle, then 0. `front_buf` = 1. A following sprite's words have bit 13 = 0 (e.g. w0 = 0x04025007).
- `req_valid` and `commit_valid` asserted together in IDLE:
  - The sprite is accepted first; `commit_ready` stays 0 that cycle.
  - The swap word follows after w3 and its gap.
- `WORD_CYCLES`=3, `GAP_CYCLES`=2: each word is held 3 cycles with 2 idle cycles between words; the sprite sequence takes 20 cycles.
- Assert `reset` during w2:
  - `writedata` goes to 0 immediately, without waiting for a clock edge.
  - `front_buf` = 0.
  - After release, a new sprite starts cleanly at w0 with buffer bit 1.

Source files
------------

// File: rtl/sprite_cmd_encoder.sv
// Sprite command-word transmitter: serialises one sprite descriptor into four
// display command words, or emits a buffer-swap word, each followed by idle gaps.
module sprite_cmd_encoder #(
    parameter int unsigned WORD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_component,
    input  logic [4:0]  req_subcomponent,
    input  logic [4:0]  req_pattern,
    input  logic        req_visible,
    input  logic        req_flip,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    input  logic [9:0]  req_attr,
    input  logic        commit_valid,
    output logic        commit_ready,
    output logic [31:0] writedata,
    output logic        front_buf,
    output logic        busy
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WORD_W     = 32;
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0] CMD_SPRITE = 4'b0001;
    localparam logic [3:0] CMD_SWAP   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORD,
        S_GAP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_idx, w_idx_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_swap, w_swap_nxt;
    logic              r_buf, w_buf_nxt;
    logic              r_front_buf, w_front_buf_nxt;
    logic [WORD_W-1:0] r_writedata, w_writedata_nxt;

    logic [5:0]        r_comp;
    logic [4:0]        r_sub;
    logic [4:0]        r_pattern;
    logic              r_visible;
    logic              r_flip;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [9:0]        r_attr;

    logic              w_idle;
    logic              w_req_accept;
    logic              w_commit_accept;

    // Build sprite word <idx> (0: pattern/flags, 1: X, 2: Y, 3: attribute).
    function automatic logic [WORD_W-1:0] f_sprite_word(
        input logic [5:0] comp,
        input logic [4:0] sub,
        input logic [4:0] pattern,
        input logic       visible,
        input logic       flip,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] attr,
        input logic       bufbit,
        input logic [1:0] idx
    );
        logic [12:0] data;
        logic [2:0]  wtype;
        wtype = 3'(idx) + 3'd1;
        case (idx)
            2'd0:    data = {visible, flip, 6'b0, pattern};
            2'd1:    data = {3'b0, x};
            2'd2:    data = {3'b0, y};
            default: data = {3'b0, attr};
        endcase
        return {comp, sub, CMD_SPRITE, wtype, bufbit, data};
    endfunction

    // Handshake: sprite requests win over a simultaneous commit; both blocked in reset.
    assign w_idle          = (r_state == S_IDLE);
    assign req_ready       = w_idle && !reset;
    assign commit_ready    = w_idle && !reset && !req_valid;
    assign w_req_accept    = req_valid && req_ready;
    assign w_commit_accept = commit_valid && commit_ready;

    assign writedata = r_writedata;
    assign front_buf = r_front_buf;
    assign busy      = !w_idle;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            r_swap      <= 1'b0;
            r_buf       <= 1'b0;
            r_front_buf <= 1'b0;
            r_writedata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_swap      <= w_swap_nxt;
            r_buf       <= w_buf_nxt;
            r_front_buf <= w_front_buf_nxt;
            r_writedata <= w_writedata_nxt;
        end
    end

    // Latch the descriptor on accept; it is ignored for the rest of the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_comp    <= '0;
            r_sub     <= '0;
            r_pattern <= '0;
            r_visible <= 1'b0;
            r_flip    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_attr    <= '0;
        end else if (w_req_accept) begin
            r_comp    <= req_component;
            r_sub     <= req_subcomponent;
            r_pattern <= req_pattern;
            r_visible <= req_visible;
            r_flip    <= req_flip;
            r_x       <= req_x;
            r_y       <= req_y;
            r_attr    <= req_attr;
        end
    end

    // Next-state and next-word logic: WORD holds a word, GAP holds idle, then advance.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_swap_nxt      = r_swap;
        w_buf_nxt       = r_buf;
        w_front_buf_nxt = r_front_buf;
        w_writedata_nxt = r_writedata;

        case (r_state)
            S_IDLE: begin
                w_writedata_nxt = '0;
                if (w_req_accept) begin
                    w_buf_nxt       = ~r_front_buf;
                    w_idx_nxt       = 2'd0;
                    w_cnt_nxt       = '0;
                    w_swap_nxt      = 1'b0;
                    w_writedata_nxt = f_sprite_word(req_component, req_subcomponent,
                                                    req_pattern, req_visible, req_flip,
                                                    req_x, req_y, req_attr,
                                                    ~r_front_buf, 2'd0);
                    w_state_nxt     = S_WORD;
                end else if (w_commit_accept) begin
                    w_front_buf_nxt = ~r_front_buf;
                    w_cnt_nxt       = '0;
                    w_swap_nxt      = 1'b1;
                    w_writedata_nxt = {6'b0, 5'b0, CMD_SWAP, 3'b0, ~r_front_buf, 13'b0};
                    w_state_nxt     = S_WORD;
                end
            end

            S_WORD: begin
                if (r_cnt == WORD_LAST) begin
                    w_cnt_nxt       = '0;
                    w_writedata_nxt = '0;
                    w_state_nxt     = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_swap && (r_idx != 2'd3)) begin
                        w_idx_nxt       = r_idx + 2'd1;
                        w_writedata_nxt = f_sprite_word(r_comp, r_sub, r_pattern,
                                                        r_visible, r_flip, r_x, r_y,
                                                        r_attr, r_buf, r_idx + 2'd1);
                        w_state_nxt     = S_WORD;
                    end else begin
                        w_swap_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_writedata_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Scoreboard bench for sprite_cmd_encoder: instance A uses default timing,
// instance B uses WORD_CYCLES=3 / GAP_CYCLES=2.
module tb_sprite_cmd_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Shared descriptor inputs
    logic [5:0] d_comp;
    logic [4:0] d_sub;
    logic [4:0] d_pat;
    logic       d_vis;
    logic       d_flip;
    logic [9:0] d_x;
    logic [9:0] d_y;
    logic [9:0] d_attr;

    // Instance A
    logic        a_rst, a_req_valid, a_req_ready, a_commit_valid, a_commit_ready;
    logic [31:0] a_wd;
    logic        a_front, a_busy;
    // Instance B
    logic        b_rst, b_req_valid, b_req_ready, b_commit_valid, b_commit_ready;
    logic [31:0] b_wd;
    logic        b_front, b_busy;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    sprite_cmd_encoder u_a (
        .clk(clk), .reset(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_component(d_comp), .req_subcomponent(d_sub), .req_pattern(d_pat),
        .req_visible(d_vis), .req_flip(d_flip),
        .req_x(d_x), .req_y(d_y), .req_attr(d_attr),
        .commit_valid(a_commit_valid), .commit_ready(a_commit_ready),
        .writedata(a_wd), .front_buf(a_front), .busy(a_busy)
    );

    sprite_cmd_encoder #(.WORD_CYCLES(3), .GAP_CYCLES(2)) u_b (
        .clk(clk), .reset(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_component(d_comp), .req_subcomponent(d_sub), .req_pattern(d_pat),
        .req_visible(d_vis), .req_flip(d_flip),
        .req_x(d_x), .req_y(d_y), .req_attr(d_attr),
        .commit_valid(b_commit_valid), .commit_ready(b_commit_ready),
        .writedata(b_wd), .front_buf(b_front), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_desc(input logic [5:0] comp, input logic [4:0] sub,
                            input logic [4:0] pat, input logic vis, input logic flip,
                            input logic [9:0] x, input logic [9:0] y, input logic [9:0] attr);
        d_comp = comp; d_sub = sub; d_pat = pat; d_vis = vis; d_flip = flip;
        d_x = x; d_y = y; d_attr = attr;
    endtask

    // Count edges (called #1 after an edge) until instance A is ready again.
    task automatic wait_ready_a(output int n);
        n = 0;
        while (!a_req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Accept one sprite on A; returns #1 after the accept edge.
    task automatic accept_req_a();
        int n;
        wait_ready_a(n);
        if (n >= 200) chk("a_ready_timeout", 32'(n), 32'(0));
        a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic accept_commit_a();
        int n;
        wait_ready_a(n);
        if (n >= 200) chk("a_ready_timeout", 32'(n), 32'(0));
        a_commit_valid = 1'b1;
        @(posedge clk); #1;
        a_commit_valid = 1'b0;
    endtask

    // Monitor A: each new non-idle word is popped from the scoreboard; holds checked.
    logic [31:0] a_prev = 32'h0;
    int          a_hold = 0;
    always @(negedge clk) begin
        if (!a_rst) begin
            if (a_wd != 32'h0 && a_wd != a_prev) begin
                if (a_prev != 32'h0) chk("a_gap_missing", a_prev, 32'h0);
                if (qa.size() == 0) chk("a_unexpected_word", a_wd, 32'h0);
                else chk("a_word", a_wd, qa.pop_front());
                a_hold = 1;
            end else if (a_wd != 32'h0) begin
                a_hold++;
            end else if (a_prev != 32'h0) begin
                chk("a_hold", 32'(a_hold), 32'd1);
            end
        end
        a_prev = a_wd;
    end

    // Monitor B: same scheme, words must be held three cycles.
    logic [31:0] b_prev = 32'h0;
    int          b_hold = 0;
    always @(negedge clk) begin
        if (!b_rst) begin
            if (b_wd != 32'h0 && b_wd != b_prev) begin
                if (b_prev != 32'h0) chk("b_gap_missing", b_prev, 32'h0);
                if (qb.size() == 0) chk("b_unexpected_word", b_wd, 32'h0);
                else chk("b_word", b_wd, qb.pop_front());
                b_hold = 1;
            end else if (b_wd != 32'h0) begin
                b_hold++;
            end else if (b_prev != 32'h0) begin
                chk("b_hold", 32'(b_hold), 32'd3);
            end
        end
        b_prev = b_wd;
    end

    initial begin
        int n;
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 1'b0; a_commit_valid = 1'b0;
        b_req_valid = 1'b0; b_commit_valid = 1'b0;
        set_desc(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        repeat (2) @(posedge clk);
        #1;

        // In reset
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_commit_ready", 32'(a_commit_ready), 32'd0);
        chk("rst_writedata", a_wd, 32'h0);
        chk("rst_busy", 32'(a_busy), 32'd0);

        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(a_req_ready), 32'd1);
        chk("idle_commit_ready", 32'(a_commit_ready), 32'd1);
        chk("idle_front_buf", 32'(a_front), 32'd0);
        chk("idle_writedata", a_wd, 32'h0);

        // Sprite 1, accepted on first edge after release; descriptor scrambled afterwards
        set_desc(6'd1, 5'd0, 5'd7, 1'b1, 1'b0, 10'd100, 10'd200, 10'd5);
        qa.push_back(32'h04027007); qa.push_back(32'h0402A064);
        qa.push_back(32'h0402E0C8); qa.push_back(32'h04032005);
        a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        chk("spr1_busy", 32'(a_busy), 32'd1);
        chk("spr1_req_ready_low", 32'(a_req_ready), 32'd0);
        set_desc(6'h3F, 5'h1F, 5'h1F, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        wait_ready_a(n);
        chk("spr1_len", 32'(n), 32'd8);
        chk("spr1_busy_done", 32'(a_busy), 32'd0);

        // Commit from front_buf=0
        qa.push_back(32'h001E2000);
        accept_commit_a();
        chk("commit1_front", 32'(a_front), 32'd1);
        chk("commit1_busy", 32'(a_busy), 32'd1);
        wait_ready_a(n);
        chk("commit1_len", 32'(n), 32'd2);

        // Sprite after swap: buffer bit now 0
        set_desc(6'd1, 5'd0, 5'd7, 1'b1, 1'b0, 10'd100, 10'd200, 10'd5);
        qa.push_back(32'h04025007); qa.push_back(32'h04028064);
        qa.push_back(32'h0402C0C8); qa.push_back(32'h04030005);
        accept_req_a();
        wait_ready_a(n);
        chk("spr2_len", 32'(n), 32'd8);

        // Simultaneous sprite and commit: sprite first, swap after w3 and its gap
        set_desc(6'h2A, 5'h13, 5'h1F, 1'b0, 1'b1, 10'h3FF, 10'h000, 10'h2AA);
        qa.push_back(32'hAA62481F); qa.push_back(32'hAA6283FF);
        qa.push_back(32'hAA62C000); qa.push_back(32'hAA6302AA);
        qa.push_back(32'h001E0000);
        a_req_valid = 1'b1;
        a_commit_valid = 1'b1;
        #1;
        chk("both_commit_ready", 32'(a_commit_ready), 32'd0);
        chk("both_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        chk("both_front_unchanged", 32'(a_front), 32'd1);
        n = 0;
        while (!a_commit_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("both_commit_wait", 32'(n), 32'd8);
        @(posedge clk); #1;
        a_commit_valid = 1'b0;
        chk("both_front_after_swap", 32'(a_front), 32'd0);
        wait_ready_a(n);
        chk("both_swap_len", 32'(n), 32'd2);

        // Reset during w2
        qa.push_back(32'h001E2000);
        accept_commit_a();
        chk("commit3_front", 32'(a_front), 32'd1);
        wait_ready_a(n);
        set_desc(6'd3, 5'd1, 5'd2, 1'b1, 1'b1, 10'd1, 10'd2, 10'd3);
        qa.push_back(32'h0C225802); qa.push_back(32'h0C228001);
        accept_req_a();
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_w2", a_wd, 32'h0C22C002);
        a_rst = 1'b1;
        #1;
        chk("midrst_writedata", a_wd, 32'h0);
        chk("midrst_front", 32'(a_front), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_req_ready", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        #1;
        chk("postrst_req_ready", 32'(a_req_ready), 32'd1);
        set_desc(6'd1, 5'd0, 5'd7, 1'b1, 1'b0, 10'd100, 10'd200, 10'd5);
        qa.push_back(32'h04027007); qa.push_back(32'h0402A064);
        qa.push_back(32'h0402E0C8); qa.push_back(32'h04032005);
        accept_req_a();
        wait_ready_a(n);
        chk("postrst_len", 32'(n), 32'd8);

        // Instance B: WORD_CYCLES=3, GAP_CYCLES=2
        qb.push_back(32'h04027007); qb.push_back(32'h0402A064);
        qb.push_back(32'h0402E0C8); qb.push_back(32'h04032005);
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        while (!b_req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_spr_len", 32'(n), 32'd20);

        // Drain scoreboards
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
